// File: rtl/tryx_arb_pkg.sv
// Shared types for the TRYX external-port arbiter: core ID type and stall counter width.
package tryx_arb_pkg;

  localparam int ARB_NB_CORES    = 8;
  localparam int STALL_CNT_WIDTH = 32;

  typedef logic [$clog2(ARB_NB_CORES)-1:0] core_id_t;

endpackage

// File: rtl/tryx_arb_id_fifo.sv
// In-order FIFO of granted core IDs; the head names the core owning the oldest outstanding request.
module tryx_arb_id_fifo
  import tryx_arb_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type id_t  = core_id_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  id_t  data_i,
  input  logic pop_i,
  output id_t  head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  id_t              mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tryx_ext_arbiter.sv
// Round-robin arbiter sharing the external peripheral port among cores; responses are steered via an ID FIFO.
// Optional per-core stall counters are built when TRYX_EXT_ARB_STALL_CNT_EN is defined.
module tryx_ext_arbiter
  import tryx_arb_pkg::*;
#(
  parameter int  NB_CORES        = 8,
  parameter int  MAX_OUTSTANDING = 4,
  parameter type tryx_req_t      = logic
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NB_CORES-1:0]                       core_req_i,
  input  logic [NB_CORES-1:0][31:0]                 core_add_i,
  input  logic [NB_CORES-1:0]                       core_wen_i,
  input  logic [NB_CORES-1:0][31:0]                 core_wdata_i,
  input  logic [NB_CORES-1:0][3:0]                  core_be_i,
  input  tryx_req_t [NB_CORES-1:0]                  core_tryx_i,
  output logic [NB_CORES-1:0]                       core_gnt_o,
  output logic [NB_CORES-1:0]                       core_r_valid_o,
  output logic [31:0]                               core_r_rdata_o,
  output logic                                      core_r_opc_o,
  output logic [NB_CORES-1:0]                       xresp_decerr_o,
  output logic [NB_CORES-1:0]                       xresp_slverr_o,
  output logic [NB_CORES-1:0]                       xresp_valid_o,
  output logic                                      ext_req_o,
  output logic [31:0]                               ext_add_o,
  output logic                                      ext_wen_o,
  output logic [31:0]                               ext_wdata_o,
  output logic [3:0]                                ext_be_o,
  output tryx_req_t                                 ext_tryx_o,
  input  logic                                      ext_gnt_i,
  input  logic                                      ext_r_valid_i,
  input  logic [31:0]                               ext_r_rdata_i,
  input  logic                                      ext_r_opc_i,
  input  logic                                      axi_xresp_decerr_i,
  input  logic                                      axi_xresp_slverr_i,
  input  logic                                      axi_xresp_valid_i,
  output logic [NB_CORES-1:0][STALL_CNT_WIDTH-1:0]  stall_cnt_o
);

  localparam int ID_W = $clog2(NB_CORES);
  typedef logic [ID_W-1:0] id_t;

  id_t  rr_ptr_q;
  id_t  winner;
  id_t  cand;
  id_t  head;
  logic any_req;
  logic handshake;
  logic pop;
  logic fifo_full;
  logic fifo_empty;

  // Scan downwards so the candidate closest to rr_ptr_q is the last (winning) assignment.
  always_comb begin
    winner  = rr_ptr_q;
    any_req = 1'b0;
    cand    = '0;
    for (int k = NB_CORES - 1; k >= 0; k--) begin
      cand = id_t'((int'(rr_ptr_q) + k) % NB_CORES);
      if (core_req_i[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

  assign ext_req_o   = any_req & ~fifo_full & rst_ni;
  assign handshake   = ext_req_o & ext_gnt_i;
  assign ext_add_o   = core_add_i[winner];
  assign ext_wen_o   = core_wen_i[winner];
  assign ext_wdata_o = core_wdata_i[winner];
  assign ext_be_o    = core_be_i[winner];
  assign ext_tryx_o  = core_tryx_i[winner];

  assign pop            = ext_r_valid_i & ~fifo_empty;
  assign core_r_rdata_o = ext_r_rdata_i;
  assign core_r_opc_o   = ext_r_opc_i;

  always_comb begin
    core_gnt_o     = '0;
    core_r_valid_o = '0;
    xresp_valid_o  = '0;
    xresp_decerr_o = '0;
    xresp_slverr_o = '0;
    if (handshake) core_gnt_o[winner] = 1'b1;
    if (pop) begin
      core_r_valid_o[head] = 1'b1;
      xresp_valid_o[head]  = axi_xresp_valid_i;
      xresp_decerr_o[head] = axi_xresp_valid_i & axi_xresp_decerr_i;
      xresp_slverr_o[head] = axi_xresp_valid_i & axi_xresp_slverr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (handshake) begin
      rr_ptr_q <= id_t'((int'(winner) + 1) % NB_CORES);
    end
  end

  tryx_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .id_t  (id_t)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake),
    .data_i  (winner),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef TRYX_EXT_ARB_STALL_CNT_EN
  logic [NB_CORES-1:0][STALL_CNT_WIDTH-1:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NB_CORES; i++) begin
        if (core_req_i[i] && !core_gnt_o[i] && !(&stall_cnt_q[i]))
          stall_cnt_q[i] <= stall_cnt_q[i] + STALL_CNT_WIDTH'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

`ifndef SYNTHESIS
  // A response with nothing outstanding is a protocol error from the external side.
  resp_without_outstanding: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(ext_r_valid_i && fifo_empty));
`endif

endmodule

// File: tb/tb_tryx_ext_arbiter.sv
// Scoreboard testbench for tryx_ext_arbiter: expected grants/IDs are queued at stimulus time and checked on response.
module tb_tryx_ext_arbiter;

  localparam int NB  = 8;
  localparam int MAX = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic [NB-1:0]        core_req, core_wen, core_tryx;
  logic [NB-1:0][31:0]  core_add, core_wdata;
  logic [NB-1:0][3:0]   core_be;
  logic [NB-1:0]        core_gnt, core_r_valid, xdec, xslv, xval;
  logic [31:0]          r_rdata;
  logic                 r_opc;
  logic                 ext_req, ext_wen, ext_tryx;
  logic [31:0]          ext_add, ext_wdata;
  logic [3:0]           ext_be;
  logic                 ext_gnt, ext_r_valid, ext_r_opc;
  logic [31:0]          ext_r_rdata;
  logic                 axi_dec, axi_slv, axi_val;
  logic [NB-1:0][31:0]  stall_cnt;

  int          vectors = 0;
  int          miscompares = 0;
  int          m_rr = 0;
  int          exp_id_q[$];
  int          grant_log[$];
  logic [31:0] m_stall [NB];
  logic [NB-1:0] obs_gnt, obs_rv, obs_xd, obs_xv;
  logic          obs_ext_req;
  logic [31:0]   obs_rdata, obs_stall4;

  always #5 clk_i = ~clk_i;

  tryx_ext_arbiter #(.NB_CORES(NB), .MAX_OUTSTANDING(MAX)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .core_req_i         (core_req),
    .core_add_i         (core_add),
    .core_wen_i         (core_wen),
    .core_wdata_i       (core_wdata),
    .core_be_i          (core_be),
    .core_tryx_i        (core_tryx),
    .core_gnt_o         (core_gnt),
    .core_r_valid_o     (core_r_valid),
    .core_r_rdata_o     (r_rdata),
    .core_r_opc_o       (r_opc),
    .xresp_decerr_o     (xdec),
    .xresp_slverr_o     (xslv),
    .xresp_valid_o      (xval),
    .ext_req_o          (ext_req),
    .ext_add_o          (ext_add),
    .ext_wen_o          (ext_wen),
    .ext_wdata_o        (ext_wdata),
    .ext_be_o           (ext_be),
    .ext_tryx_o         (ext_tryx),
    .ext_gnt_i          (ext_gnt),
    .ext_r_valid_i      (ext_r_valid),
    .ext_r_rdata_i      (ext_r_rdata),
    .ext_r_opc_i        (ext_r_opc),
    .axi_xresp_decerr_i (axi_dec),
    .axi_xresp_slverr_i (axi_slv),
    .axi_xresp_valid_i  (axi_val),
    .stall_cnt_o        (stall_cnt)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expStall(input int i);
`ifdef TRYX_EXT_ARB_STALL_CNT_EN
    return m_stall[i];
`else
    return (i < 0) ? 32'hFFFF_FFFF : 32'h0;
`endif
  endfunction

  // One clock cycle: drive at negedge, compare combinational outputs 1ns later, then advance the model.
  task automatic applyStimulus(input logic [NB-1:0] req, input logic gnt, input logic rv,
                               input logic [31:0] rdata, input logic opc,
                               input logic xv, input logic xd, input logic xs);
    int win, c, h;
    logic exp_req, hs, pop;
    logic [NB-1:0] exp_gnt, exp_rv, exp_xv, exp_xd, exp_xs;
    @(negedge clk_i);
    core_req = req; ext_gnt = gnt; ext_r_valid = rv; ext_r_rdata = rdata; ext_r_opc = opc;
    axi_val = xv; axi_dec = xd; axi_slv = xs;
    #1;
    win = -1;
    for (int k = NB - 1; k >= 0; k--) begin
      c = (m_rr + k) % NB;
      if (req[c]) win = c;
    end
    exp_req = (win >= 0) && (exp_id_q.size() < MAX);
    hs = exp_req && gnt;
    exp_gnt = '0; exp_rv = '0; exp_xv = '0; exp_xd = '0; exp_xs = '0;
    if (hs) exp_gnt[win] = 1'b1;
    pop = rv && (exp_id_q.size() > 0);
    h = pop ? exp_id_q[0] : 0;
    if (pop) begin
      exp_rv[h] = 1'b1;
      exp_xv[h] = xv;
      exp_xd[h] = xv & xd;
      exp_xs[h] = xv & xs;
    end
    checkOutput("ext_req", ext_req, exp_req);
    checkOutput("core_gnt", core_gnt, exp_gnt);
    checkOutput("core_r_valid", core_r_valid, exp_rv);
    checkOutput("xresp", {xval, xdec, xslv}, {exp_xv, exp_xd, exp_xs});
    for (int i = 0; i < NB; i++) checkOutput("stall_cnt", stall_cnt[i], expStall(i));
    if (win >= 0) begin
      checkOutput("ext_add", ext_add, core_add[win]);
      checkOutput("ext_wdata", ext_wdata, core_wdata[win]);
      checkOutput("ext_ctrl", {ext_wen, ext_be, ext_tryx}, {core_wen[win], core_be[win], core_tryx[win]});
    end
    if (rv) checkOutput("r_data_opc", {r_opc, r_rdata}, {opc, rdata});
    obs_gnt = core_gnt; obs_rv = core_r_valid; obs_xd = xdec; obs_xv = xval;
    obs_ext_req = ext_req; obs_rdata = r_rdata; obs_stall4 = stall_cnt[4];
    if (hs) begin
      exp_id_q.push_back(win);
      grant_log.push_back(win);
      m_rr = (win + 1) % NB;
    end
    if (pop) void'(exp_id_q.pop_front());
    for (int i = 0; i < NB; i++)
      if (req[i] && !exp_gnt[i] && m_stall[i] != 32'hFFFF_FFFF) m_stall[i] = m_stall[i] + 1;
  endtask

  task automatic idleCycle();
    applyStimulus('0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic respond(input logic [31:0] rdata);
    applyStimulus('0, 1'b0, 1'b1, rdata, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asserts reset with the given request activity still applied, checks outputs, then releases idle.
  task automatic resetDut(input logic [NB-1:0] req, input logic gnt);
    @(negedge clk_i);
    core_req = req; ext_gnt = gnt; ext_r_valid = 1'b0; axi_val = 1'b0; axi_dec = 1'b0; axi_slv = 1'b0;
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_ext_req", ext_req, 1'b0);
    checkOutput("rst_core_gnt", core_gnt, '0);
    checkOutput("rst_r_valid", core_r_valid, '0);
    checkOutput("rst_xresp", {xval, xdec, xslv}, '0);
    for (int i = 0; i < NB; i++) checkOutput("rst_stall_cnt", stall_cnt[i], 32'h0);
    m_rr = 0;
    exp_id_q.delete();
    grant_log.delete();
    for (int i = 0; i < NB; i++) m_stall[i] = 32'h0;
    @(negedge clk_i);
    core_req = '0; ext_gnt = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic checkGrantOrder(input string tag, input int n, input int exp [4]);
    for (int k = 0; k < n; k++)
      checkOutput(tag, (grant_log.size() > k) ? grant_log[k] : -1, exp[k]);
  endtask

  initial begin
    int ord[4];
    for (int i = 0; i < NB; i++) begin
      core_add[i]   = 32'h1000_0000 + (i << 8);
      core_wdata[i] = 32'hA000_0000 + i;
      core_be[i]    = 4'(i + 1);
      m_stall[i]    = 32'h0;
    end
    core_add[2] = 32'h4000_0000;
    core_wen  = 8'h55;
    core_tryx = 8'h3C;
    core_req = '0; ext_gnt = 1'b0; ext_r_valid = 1'b0; ext_r_rdata = '0; ext_r_opc = 1'b0;
    axi_val = 1'b0; axi_dec = 1'b0; axi_slv = 1'b0;

    resetDut('0, 1'b0);

    // Single read from core 2, response three cycles later
    applyStimulus(8'h04, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_gnt", obs_gnt, 8'h04);
    idleCycle();
    checkOutput("t1_gnt_once", obs_gnt, 8'h00);
    idleCycle();
    applyStimulus('0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_r_valid", obs_rv, 8'h04);
    checkOutput("t1_rdata", obs_rdata, 32'hDEAD_BEEF);

    // Round-robin among cores 0, 3, 5
    resetDut('0, 1'b0);
    repeat (4) applyStimulus(8'h29, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    ord = '{0, 3, 5, 0};
    checkGrantOrder("rr_order", 4, ord);
    for (int k = 0; k < 4; k++) respond(32'h100 + k);

    // Outstanding limit: 4 grants, stall, grant resumes the cycle after a pop
    resetDut('0, 1'b0);
    repeat (4) applyStimulus(8'hFF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("full_ext_req", obs_ext_req, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b1, 32'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("full_no_bypass", obs_gnt, 8'h00);
    applyStimulus(8'hFF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("full_resume", obs_gnt, 8'h10);
    for (int k = 0; k < 4; k++) respond(32'h200 + k);

    // Error responses routed to IDs 1, 6, 1
    resetDut('0, 1'b0);
    applyStimulus(8'h02, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("xr1_decerr", obs_xd, 8'h00);
    checkOutput("xr1_valid", obs_xv, 8'h02);
    applyStimulus('0, 1'b0, 1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("xr2_decerr", obs_xd, 8'h40);
    applyStimulus('0, 1'b0, 1'b1, 32'h33, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("xr3_decerr", obs_xd, 8'h00);
    checkOutput("xr3_r_valid", obs_rv, 8'h02);

    // Winner held while the external grant is low
    resetDut('0, 1'b0);
    repeat (5) applyStimulus(8'h06, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h06, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_first", obs_gnt, 8'h02);
    applyStimulus(8'h04, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_second", obs_gnt, 8'h04);
    respond(32'h44);
    respond(32'h55);

    // Stall counting on core 4, then reset in the middle of a burst
    resetDut('0, 1'b0);
    repeat (7) applyStimulus(8'h10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycle();
`ifdef TRYX_EXT_ARB_STALL_CNT_EN
    checkOutput("stall_core4", obs_stall4, 32'd7);
`else
    checkOutput("stall_core4", obs_stall4, 32'd0);
`endif
    repeat (2) applyStimulus(8'hFF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    resetDut(8'hFF, 1'b1);
    repeat (4) applyStimulus(8'hFF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    ord = '{0, 1, 2, 3};
    checkGrantOrder("post_rst_order", 4, ord);
    for (int k = 0; k < 4; k++) respond(32'h300 + k);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
